// File: rtl/cajero_automatico.sv
// ATM transaction controller: card detect, 4-digit PIN check,
// deposit/withdrawal against an internal balance, lockout after 3 failures.
module cajero_automatico #(
  parameter int                   BALANCE_W       = 64,
  parameter logic [BALANCE_W-1:0] BALANCE_INICIAL = BALANCE_W'(300000)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 TARJETA_RECIBIDA,
  input  logic [15:0]          PIN,
  input  logic [3:0]           DIGITO,
  input  logic                 DIGITO_STB,
  input  logic                 TIPO_TRANS,
  input  logic [31:0]          MONTO,
  input  logic                 MONTO_STB,
  output logic [BALANCE_W-1:0] BALANCE,
  output logic                 BALANCE_ACTUALIZADO,
  output logic                 ENTREGAR_DINERO,
  output logic                 FONDOS_INSUFICIENTES,
  output logic                 PIN_INCORRECTO,
  output logic [1:0]           ADVERTENCIA,
  output logic                 BLOQUEO
);

  typedef enum logic [2:0] {
    S_ESPERA_TARJETA,
    S_PIN,
    S_AUTORIZADO,
    S_TRANSACCION,
    S_FIN,
    S_BLOQUEADO
  } estado_t;

  estado_t              estado;
  logic [15:0]          pin_q;
  logic [1:0]           idx;
  logic [31:0]          monto_q;
  logic                 tipo_q;
  logic                 monto_valido;
  logic                 dig_prev;
  logic                 monto_prev;
  logic [3:0]           esperado;
  logic                 dig_ev;
  logic                 monto_ev;
  logic                 captura;
  logic [BALANCE_W-1:0] monto_ext;

  assign dig_ev    = DIGITO_STB & ~dig_prev;
  assign monto_ev  = MONTO_STB & ~monto_prev;
  assign captura   = monto_ev &
                     ((estado == S_PIN) || (estado == S_AUTORIZADO));
  assign monto_ext = {{(BALANCE_W-32){1'b0}}, monto_q};

  // PIN nibbles are entered most-significant first
  always_comb begin
    esperado = pin_q[15:12];
    unique case (idx)
      2'd0: esperado = pin_q[15:12];
      2'd1: esperado = pin_q[11:8];
      2'd2: esperado = pin_q[7:4];
      2'd3: esperado = pin_q[3:0];
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      estado               <= S_ESPERA_TARJETA;
      pin_q                <= '0;
      idx                  <= '0;
      monto_q              <= '0;
      tipo_q               <= 1'b0;
      monto_valido         <= 1'b0;
      dig_prev             <= 1'b0;
      monto_prev           <= 1'b0;
      BALANCE              <= BALANCE_INICIAL;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;
      ADVERTENCIA          <= '0;
      BLOQUEO              <= 1'b0;
    end else begin
      dig_prev             <= DIGITO_STB;
      monto_prev           <= MONTO_STB;
      BALANCE_ACTUALIZADO  <= 1'b0;
      ENTREGAR_DINERO      <= 1'b0;
      FONDOS_INSUFICIENTES <= 1'b0;
      PIN_INCORRECTO       <= 1'b0;

      if (captura) begin
        monto_q      <= MONTO;
        tipo_q       <= TIPO_TRANS;
        monto_valido <= 1'b1;
      end

      unique case (estado)
        S_ESPERA_TARJETA: begin
          if (TARJETA_RECIBIDA) begin
            estado       <= S_PIN;
            pin_q        <= PIN;
            idx          <= '0;
            monto_valido <= 1'b0;
          end
        end
        S_PIN: begin
          if (!TARJETA_RECIBIDA) begin
            estado       <= S_ESPERA_TARJETA;
            monto_valido <= 1'b0;
          end else if (dig_ev) begin
            if (DIGITO == esperado) begin
              if (idx == 2'd3) begin
                estado      <= S_AUTORIZADO;
                ADVERTENCIA <= '0;
              end else begin
                idx <= idx + 2'd1;
              end
            end else begin
              PIN_INCORRECTO <= 1'b1;
              idx            <= '0;
              if (ADVERTENCIA >= 2'd2) begin
                ADVERTENCIA <= 2'd3;
                BLOQUEO     <= 1'b1;
                estado      <= S_BLOQUEADO;
              end else begin
                ADVERTENCIA <= ADVERTENCIA + 2'd1;
              end
            end
          end
        end
        S_AUTORIZADO: begin
          if (!TARJETA_RECIBIDA) begin
            estado       <= S_ESPERA_TARJETA;
            monto_valido <= 1'b0;
          end else if (monto_valido) begin
            estado <= S_TRANSACCION;
          end
        end
        S_TRANSACCION: begin
          estado       <= S_FIN;
          monto_valido <= 1'b0;
          if (!tipo_q) begin
            BALANCE             <= BALANCE + monto_ext;
            BALANCE_ACTUALIZADO <= 1'b1;
          end else if (monto_ext <= BALANCE) begin
            BALANCE             <= BALANCE - monto_ext;
            BALANCE_ACTUALIZADO <= 1'b1;
            ENTREGAR_DINERO     <= 1'b1;
          end else begin
            FONDOS_INSUFICIENTES <= 1'b1;
          end
        end
        S_FIN: begin
          if (!TARJETA_RECIBIDA) estado <= S_ESPERA_TARJETA;
        end
        S_BLOQUEADO: begin
          BLOQUEO <= 1'b1;
        end
        default: estado <= S_ESPERA_TARJETA;
      endcase
    end
  end

endmodule

// File: tb/tb_cajero_automatico.sv
// Randomized session-level bench for cajero_automatico with a
// transaction-level model of balance, attempts and lockout.
module tb_cajero_automatico;

  localparam logic [63:0] BINI = 64'd300000;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        TARJETA_RECIBIDA = 1'b0;
  logic [15:0] PIN = '0;
  logic [3:0]  DIGITO = '0;
  logic        DIGITO_STB = 1'b0;
  logic        TIPO_TRANS = 1'b0;
  logic [31:0] MONTO = '0;
  logic        MONTO_STB = 1'b0;
  logic [63:0] BALANCE;
  logic        BALANCE_ACTUALIZADO;
  logic        ENTREGAR_DINERO;
  logic        FONDOS_INSUFICIENTES;
  logic        PIN_INCORRECTO;
  logic [1:0]  ADVERTENCIA;
  logic        BLOQUEO;

  always #5 CLK = ~CLK;

  cajero_automatico dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .TARJETA_RECIBIDA    (TARJETA_RECIBIDA),
    .PIN                 (PIN),
    .DIGITO              (DIGITO),
    .DIGITO_STB          (DIGITO_STB),
    .TIPO_TRANS          (TIPO_TRANS),
    .MONTO               (MONTO),
    .MONTO_STB           (MONTO_STB),
    .BALANCE             (BALANCE),
    .BALANCE_ACTUALIZADO (BALANCE_ACTUALIZADO),
    .ENTREGAR_DINERO     (ENTREGAR_DINERO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES),
    .PIN_INCORRECTO      (PIN_INCORRECTO),
    .ADVERTENCIA         (ADVERTENCIA),
    .BLOQUEO             (BLOQUEO)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_upd = 0, n_ent = 0, n_fon = 0, n_inc = 0, n_both = 0;
  int last_res = -1;
  int last_stb = 0;

  always @(posedge CLK) cyc++;

  // Pulse monitor, sampled mid-cycle
  always @(negedge CLK) begin
    if (BALANCE_ACTUALIZADO) n_upd++;
    if (ENTREGAR_DINERO) n_ent++;
    if (FONDOS_INSUFICIENTES) n_fon++;
    if (PIN_INCORRECTO) n_inc++;
    if (BALANCE_ACTUALIZADO && ENTREGAR_DINERO) n_both++;
    if (BALANCE_ACTUALIZADO || FONDOS_INSUFICIENTES) last_res = cyc;
  end

  logic [63:0] m_bal;
  int          m_adv;
  bit          m_lock;
  logic [15:0] m_pin;
  bit          m_pend;
  bit          m_tipo;
  logic [31:0] m_monto;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [3:0] nib(input int i);
    return m_pin[15-4*i -: 4];
  endfunction

  function automatic int hold_of(input int h);
    return (h == 0) ? int'($urandom_range(1, 3)) : h;
  endfunction

  task automatic strobe(input logic [3:0] d, input int hold);
    DIGITO = d;
    DIGITO_STB = 1'b1;
    tick();
    last_stb = cyc;
    repeat (hold - 1) tick();
    DIGITO_STB = 1'b0;
    DIGITO = 4'($urandom);
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    TARJETA_RECIBIDA = 1'b0;
    DIGITO_STB = 1'b0;
    MONTO_STB = 1'b0;
    m_bal = BINI;
    m_adv = 0;
    m_lock = 0;
    m_pend = 0;
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("rst_balance", BALANCE, m_bal);
    chk("rst_advertencia", 64'(ADVERTENCIA), 64'(m_adv));
    chk("rst_bloqueo", 64'(BLOQUEO), 64'(m_lock));
  endtask

  task automatic open_card(input logic [15:0] p);
    m_pin = p;
    PIN = p;
    TARJETA_RECIBIDA = 1'b1;
    tick();
    PIN = 16'($urandom);
    m_pend = 0;
  endtask

  task automatic close_card();
    TARJETA_RECIBIDA = 1'b0;
    tick();
    m_pend = 0;
  endtask

  task automatic send_amount(input bit tipo, input logic [31:0] monto);
    TIPO_TRANS = tipo;
    MONTO = monto;
    MONTO_STB = 1'b1;
    tick();
    last_stb = cyc;
    MONTO_STB = 1'b0;
    tick();
    MONTO = $urandom;
    TIPO_TRANS = 1'($urandom);
    if (!m_lock) begin
      m_pend = 1;
      m_tipo = tipo;
      m_monto = monto;
    end
  endtask

  task automatic fail_attempt(input int pfx, input logic [3:0] w);
    int inc0;
    inc0 = n_inc;
    for (int i = 0; i < pfx; i++) strobe(nib(i), hold_of(0));
    strobe(w, hold_of(0));
    if (m_adv < 3) m_adv++;
    if (m_adv == 3) m_lock = 1;
    chk("pin_incorrecto_pulse", 64'(n_inc - inc0), 64'd1);
    chk("advertencia", 64'(ADVERTENCIA), 64'(m_adv));
    chk("bloqueo", 64'(BLOQUEO), 64'(m_lock));
  endtask

  function automatic logic [3:0] wrong_of(input int pfx);
    return nib(pfx) + 4'($urandom_range(1, 15));
  endfunction

  task automatic pass_pin(input int h);
    for (int i = 0; i < 4; i++) strobe(nib(i), hold_of(h));
    m_adv = 0;
    chk("advertencia_clear", 64'(ADVERTENCIA), 64'd0);
  endtask

  task automatic locked_probe();
    int u0, e0, f0, i0;
    u0 = n_upd; e0 = n_ent; f0 = n_fon; i0 = n_inc;
    for (int i = 0; i < 4; i++) strobe(nib(i), 1);
    send_amount(1'b1, 32'd1000);
    repeat (3) tick();
    chk("locked_no_pulses",
        64'((n_upd - u0) + (n_ent - e0) + (n_fon - f0) + (n_inc - i0)),
        64'd0);
    chk("locked_bloqueo", 64'(BLOQUEO), 64'd1);
    chk("locked_advertencia", 64'(ADVERTENCIA), 64'd3);
    chk("locked_balance", BALANCE, m_bal);
  endtask

  task automatic session(input logic [15:0] p, input bit tipo,
                         input logic [31:0] monto, input int nfail,
                         input bit amt_first, input int h);
    int u0, e0, f0, b0, i0;
    int eu, ee, ef;
    logic [63:0] mx;
    open_card(p);
    if (amt_first) send_amount(tipo, monto);
    for (int f = 0; f < nfail && !m_lock; f++) begin
      int pfx;
      pfx = int'($urandom_range(0, 3));
      fail_attempt(pfx, wrong_of(pfx));
    end
    if (m_lock) begin
      locked_probe();
      do_reset();
      return;
    end
    u0 = n_upd; e0 = n_ent; f0 = n_fon; b0 = n_both; i0 = n_inc;
    pass_pin(h);
    if (!amt_first) send_amount(tipo, monto);
    repeat (3) tick();
    eu = 0; ee = 0; ef = 0;
    mx = {32'd0, m_monto};
    if (!m_tipo) begin
      m_bal = m_bal + mx;
      eu = 1;
    end else if (mx <= m_bal) begin
      m_bal = m_bal - mx;
      eu = 1;
      ee = 1;
    end else begin
      ef = 1;
    end
    m_pend = 0;
    chk("balance_actualizado", 64'(n_upd - u0), 64'(eu));
    chk("entregar_dinero", 64'(n_ent - e0), 64'(ee));
    chk("fondos_insuficientes", 64'(n_fon - f0), 64'(ef));
    chk("entregar_with_update", 64'(n_both - b0), 64'(ee));
    chk("no_pin_incorrecto", 64'(n_inc - i0), 64'd0);
    chk("balance", BALANCE, m_bal);
    chk("latency", 64'(last_res), 64'(last_stb + 2));
    close_card();
  endtask

  function automatic logic [15:0] rand_pin();
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) p = {p[11:0], 4'($urandom_range(0, 9))};
    return p;
  endfunction

  initial begin
    int u0, e0, f0;
    do_reset();

    session(16'h6767, 1'b0, 32'd150000, 0, 1'b1, 1);
    chk("deposit_balance", BALANCE, 64'd450000);

    do_reset();
    session(16'h6767, 1'b1, 32'd350000, 0, 1'b1, 0);
    chk("insufficient_balance", BALANCE, 64'd300000);

    do_reset();
    session(16'h6767, 1'b1, 32'd300000, 0, 1'b0, 3);
    chk("exact_balance", BALANCE, 64'd0);

    do_reset();
    open_card(16'h6767);
    fail_attempt(2, 4'd1);
    fail_attempt(3, 4'd1);
    fail_attempt(1, 4'd9);
    locked_probe();
    do_reset();
    session(16'h6767, 1'b1, 32'd75000, 0, 1'b1, 0);
    chk("after_lock_balance", BALANCE, 64'd225000);

    // card pulled mid-PIN keeps the attempt count
    open_card(16'h1234);
    fail_attempt(1, 4'd5);
    strobe(nib(0), 3);
    strobe(nib(1), 1);
    close_card();
    chk("removal_advertencia", 64'(ADVERTENCIA), 64'd1);
    session(16'h4321, 1'b0, 32'd5, 0, 1'b0, 0);

    // reset while the transaction is in flight
    open_card(16'h9090);
    send_amount(1'b0, 32'd1000);
    u0 = n_upd; e0 = n_ent; f0 = n_fon;
    for (int i = 0; i < 4; i++) strobe(nib(i), 1);
    RESET = 1'b1;
    m_bal = BINI; m_adv = 0; m_lock = 0; m_pend = 0;
    TARJETA_RECIBIDA = 1'b0;
    tick();
    tick();
    chk("rst_txn_no_pulses",
        64'((n_upd - u0) + (n_ent - e0) + (n_fon - f0)), 64'd0);
    RESET = 1'b0;
    tick();
    chk("rst_txn_balance", BALANCE, BINI);

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) begin
        int pfx;
        open_card(rand_pin());
        pfx = int'($urandom_range(0, 3));
        for (int i = 0; i < pfx; i++) strobe(nib(i), hold_of(0));
        if ($urandom_range(0, 1) == 1) send_amount(1'b0, 32'd7);
        close_card();
        chk("rnd_removal_adv", 64'(ADVERTENCIA), 64'(m_adv));
        chk("rnd_removal_bal", BALANCE, m_bal);
      end
      session(rand_pin(), 1'($urandom), 32'($urandom_range(0, 400000)),
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
              1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
